// File: rtl/wide_narrow_bank_mux.sv
// Bank-access stage: per-group arbitration between narrow bank requests and atomic wide
// requests, SRAM port drive, and fixed-latency read-response routing back to the owner.
`timescale 1ns/1ps
module wide_narrow_bank_mux #(
   parameter int NumNarrowBanks = 8,
   parameter int WideToNarrow   = 4,
   parameter int BankAddrWidth  = 10,
   parameter int DataWidth      = 64,
   parameter int BankLatency    = 1,
   parameter int ArbMode        = 0,
   parameter int MaxWideStall   = 4,
   localparam int NumGroups     = NumNarrowBanks / WideToNarrow,
   localparam int BeWidth       = DataWidth / 8
) (
   input  logic                                          clk_i,
   input  logic                                          rst_ni,
   input  logic [NumNarrowBanks-1:0]                     narrow_req_i,
   output logic [NumNarrowBanks-1:0]                     narrow_gnt_o,
   input  logic [NumNarrowBanks*BankAddrWidth-1:0]       narrow_addr_i,
   input  logic [NumNarrowBanks-1:0]                     narrow_we_i,
   input  logic [NumNarrowBanks*DataWidth-1:0]           narrow_wdata_i,
   input  logic [NumNarrowBanks*BeWidth-1:0]             narrow_be_i,
   output logic [NumNarrowBanks-1:0]                     narrow_rvalid_o,
   output logic [NumNarrowBanks*DataWidth-1:0]           narrow_rdata_o,
   input  logic [NumGroups-1:0]                          wide_req_i,
   output logic [NumGroups-1:0]                          wide_gnt_o,
   input  logic [NumGroups*BankAddrWidth-1:0]            wide_addr_i,
   input  logic [NumGroups-1:0]                          wide_we_i,
   input  logic [NumGroups*WideToNarrow*DataWidth-1:0]   wide_wdata_i,
   input  logic [NumGroups*WideToNarrow*BeWidth-1:0]     wide_be_i,
   output logic [NumGroups-1:0]                          wide_rvalid_o,
   output logic [NumGroups*WideToNarrow*DataWidth-1:0]   wide_rdata_o,
   output logic [NumNarrowBanks-1:0]                     bank_req_o,
   output logic [NumNarrowBanks*BankAddrWidth-1:0]       bank_addr_o,
   output logic [NumNarrowBanks-1:0]                     bank_we_o,
   output logic [NumNarrowBanks*DataWidth-1:0]           bank_wdata_o,
   output logic [NumNarrowBanks*BeWidth-1:0]             bank_be_o,
   input  logic [NumNarrowBanks*DataWidth-1:0]           bank_rdata_i
);

   // Handshake: a request is accepted in the cycle where req and gnt are both high; an
   // ungranted request may be held or withdrawn, and nothing is remembered about it.
   localparam int StallWidth = $clog2(MaxWideStall + 1);
   localparam logic [StallWidth-1:0] MaxStall = StallWidth'(MaxWideStall);

   logic [NumGroups-1:0]                         narrow_any;
   logic [NumGroups-1:0]                         conflict;
   logic [NumGroups-1:0]                         wide_win;
   logic [NumNarrowBanks-1:0]                    narrow_win;
   logic [StallWidth-1:0]                        stall_cnt [NumGroups];
   logic [NumGroups-1:0]                         rr;
   logic [NumNarrowBanks-1:0][BankLatency-1:0]   n_pipe;
   logic [NumNarrowBanks-1:0][BankLatency-1:0]   w_pipe;
   logic [NumNarrowBanks-1:0]                    n_push;
   logic [NumNarrowBanks-1:0]                    w_push;
   logic [NumNarrowBanks-1:0]                    n_tail;
   logic [NumNarrowBanks-1:0]                    w_tail;

   always_comb begin
      narrow_any = '0;
      conflict   = '0;
      wide_win   = '0;
      narrow_win = '0;
      n_push     = '0;
      w_push     = '0;
      for (int g = 0; g < NumGroups; g++) begin
         narrow_any[g] = |narrow_req_i[g*WideToNarrow +: WideToNarrow];
         conflict[g]   = wide_req_i[g] && narrow_any[g];
         case (ArbMode)
            0:       wide_win[g] = wide_req_i[g] && (!narrow_any[g] || (stall_cnt[g] == MaxStall));
            1:       wide_win[g] = wide_req_i[g];
            default: wide_win[g] = wide_req_i[g] && (!narrow_any[g] || rr[g]);
         endcase
      end
      // A wide win owns the whole group, so narrow grants only survive where it lost.
      for (int b = 0; b < NumNarrowBanks; b++) begin
         narrow_win[b] = narrow_req_i[b] && !wide_win[b / WideToNarrow];
         n_push[b]     = narrow_win[b] && !narrow_we_i[b];
         w_push[b]     = wide_win[b / WideToNarrow] && !wide_we_i[b / WideToNarrow];
      end
   end

   assign narrow_gnt_o = narrow_win;
   assign wide_gnt_o   = wide_win;

   always_comb begin
      bank_req_o   = '0;
      bank_addr_o  = '0;
      bank_we_o    = '0;
      bank_wdata_o = '0;
      bank_be_o    = '0;
      for (int b = 0; b < NumNarrowBanks; b++) begin
         if (wide_win[b / WideToNarrow]) begin
            bank_req_o[b]                           = 1'b1;
            bank_addr_o[b*BankAddrWidth +: BankAddrWidth] =
               wide_addr_i[(b / WideToNarrow)*BankAddrWidth +: BankAddrWidth];
            bank_we_o[b]                            = wide_we_i[b / WideToNarrow];
            bank_wdata_o[b*DataWidth +: DataWidth]  = wide_wdata_i[b*DataWidth +: DataWidth];
            bank_be_o[b*BeWidth +: BeWidth]         = wide_be_i[b*BeWidth +: BeWidth];
         end else if (narrow_win[b]) begin
            bank_req_o[b]                           = 1'b1;
            bank_addr_o[b*BankAddrWidth +: BankAddrWidth] =
               narrow_addr_i[b*BankAddrWidth +: BankAddrWidth];
            bank_we_o[b]                            = narrow_we_i[b];
            bank_wdata_o[b*DataWidth +: DataWidth]  = narrow_wdata_i[b*DataWidth +: DataWidth];
            bank_be_o[b*BeWidth +: BeWidth]         = narrow_be_i[b*BeWidth +: BeWidth];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int g = 0; g < NumGroups; g++) stall_cnt[g] <= '0;
         rr     <= '0;
         n_pipe <= '0;
         w_pipe <= '0;
      end else begin
         for (int g = 0; g < NumGroups; g++) begin
            if (wide_req_i[g] && !wide_win[g]) begin
               if (stall_cnt[g] != MaxStall) stall_cnt[g] <= stall_cnt[g] + StallWidth'(1);
            end else begin
               stall_cnt[g] <= '0;
            end
            if (conflict[g]) rr[g] <= ~rr[g];
         end
         // Owner tags ride a fixed-depth shift so each one surfaces with its bank data.
         for (int b = 0; b < NumNarrowBanks; b++) begin
            for (int s = BankLatency - 1; s > 0; s--) begin
               n_pipe[b][s] <= n_pipe[b][s-1];
               w_pipe[b][s] <= w_pipe[b][s-1];
            end
            n_pipe[b][0] <= n_push[b];
            w_pipe[b][0] <= w_push[b];
         end
      end
   end

   always_comb begin
      n_tail         = '0;
      w_tail         = '0;
      wide_rvalid_o  = '0;
      narrow_rdata_o = '0;
      wide_rdata_o   = '0;
      for (int b = 0; b < NumNarrowBanks; b++) begin
         n_tail[b] = n_pipe[b][BankLatency-1];
         w_tail[b] = w_pipe[b][BankLatency-1];
      end
      for (int g = 0; g < NumGroups; g++)
         wide_rvalid_o[g] = &w_tail[g*WideToNarrow +: WideToNarrow];
      for (int b = 0; b < NumNarrowBanks; b++) begin
         if (n_tail[b])
            narrow_rdata_o[b*DataWidth +: DataWidth] = bank_rdata_i[b*DataWidth +: DataWidth];
         if (wide_rvalid_o[b / WideToNarrow])
            wide_rdata_o[b*DataWidth +: DataWidth] = bank_rdata_i[b*DataWidth +: DataWidth];
      end
   end

   assign narrow_rvalid_o = n_tail;

endmodule

// File: tb/tb_wide_narrow_bank_mux.sv
// Bench for wide_narrow_bank_mux: one instance per arbitration mode sharing stimulus, a small
// SRAM model behind the selected instance, and queue-based grant/response scoreboards.
`timescale 1ns/1ps
module tb_wide_narrow_bank_mux;
   localparam int N  = 8;
   localparam int W  = 4;
   localparam int G  = N / W;
   localparam int AW = 10;
   localparam int DW = 64;
   localparam int BW = DW / 8;
   localparam int LAT = 2;

   typedef struct {
      logic             wide;
      int               idx;
      int               due;
      logic [W*DW-1:0]  data;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   sel = 0;
   int   n_pass = 0;
   int   n_total = 0;

   logic [N-1:0]      narrow_req, narrow_we;
   logic [N*AW-1:0]   narrow_addr;
   logic [N*DW-1:0]   narrow_wdata;
   logic [N*BW-1:0]   narrow_be;
   logic [G-1:0]      wide_req, wide_we;
   logic [G*AW-1:0]   wide_addr;
   logic [G*W*DW-1:0] wide_wdata;
   logic [G*W*BW-1:0] wide_be;
   logic [N*DW-1:0]   bank_rdata;

   logic [N-1:0]      o_narrow_gnt [3];
   logic [N-1:0]      o_narrow_rvalid [3];
   logic [N*DW-1:0]   o_narrow_rdata [3];
   logic [G-1:0]      o_wide_gnt [3];
   logic [G-1:0]      o_wide_rvalid [3];
   logic [G*W*DW-1:0] o_wide_rdata [3];
   logic [N-1:0]      o_bank_req [3];
   logic [N*AW-1:0]   o_bank_addr [3];
   logic [N-1:0]      o_bank_we [3];
   logic [N*DW-1:0]   o_bank_wdata [3];
   logic [N*BW-1:0]   o_bank_be [3];

   logic [G+N-1:0] exp_q [$];
   rsp_t           exp_rsp_q [$];

   // Instance i runs arbitration mode i.
   for (genvar i = 0; i < 3; i++) begin : g_dut
      wide_narrow_bank_mux #(
         .NumNarrowBanks(N), .WideToNarrow(W), .BankAddrWidth(AW), .DataWidth(DW),
         .BankLatency(LAT), .ArbMode(i), .MaxWideStall(4)
      ) u_dut (
         .clk_i(clk), .rst_ni(rst_n),
         .narrow_req_i(narrow_req), .narrow_gnt_o(o_narrow_gnt[i]),
         .narrow_addr_i(narrow_addr), .narrow_we_i(narrow_we),
         .narrow_wdata_i(narrow_wdata), .narrow_be_i(narrow_be),
         .narrow_rvalid_o(o_narrow_rvalid[i]), .narrow_rdata_o(o_narrow_rdata[i]),
         .wide_req_i(wide_req), .wide_gnt_o(o_wide_gnt[i]),
         .wide_addr_i(wide_addr), .wide_we_i(wide_we),
         .wide_wdata_i(wide_wdata), .wide_be_i(wide_be),
         .wide_rvalid_o(o_wide_rvalid[i]), .wide_rdata_o(o_wide_rdata[i]),
         .bank_req_o(o_bank_req[i]), .bank_addr_o(o_bank_addr[i]), .bank_we_o(o_bank_we[i]),
         .bank_wdata_o(o_bank_wdata[i]), .bank_be_o(o_bank_be[i]),
         .bank_rdata_i(bank_rdata)
      );
   end

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- SRAM model (follows the selected instance) ----------------
   logic [DW-1:0] mem [N][1024];
   logic [DW-1:0] p1 [N];
   logic [DW-1:0] p2 [N];
   bit            mem_ready = 1'b0;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int b = 0; b < N; b++)
            for (int a = 0; a < 1024; a++)
               mem[b][a] <= (b < W && a == 5) ? DW'(8'hA0 + b) : {16'hBEEF, 16'(b), 32'(a)};
         mem_ready <= 1'b1;
      end else begin
         for (int b = 0; b < N; b++) begin
            if (o_bank_req[sel][b] && o_bank_we[sel][b]) begin
               for (int j = 0; j < BW; j++)
                  if (o_bank_be[sel][b*BW + j])
                     mem[b][o_bank_addr[sel][b*AW +: AW]][j*8 +: 8] <= o_bank_wdata[sel][b*DW + j*8 +: 8];
            end
            p1[b] <= (o_bank_req[sel][b] && !o_bank_we[sel][b]) ? mem[b][o_bank_addr[sel][b*AW +: AW]] : '0;
            p2[b] <= p1[b];
         end
      end
   end

   always_comb begin
      bank_rdata = '0;
      for (int b = 0; b < N; b++) bank_rdata[b*DW +: DW] = p2[b];
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [W*DW-1:0] act, input logic [W*DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d, mode %0d)", name, act, exp, cyc, sel);
   endtask

   task automatic mon_rsp(input logic wide, input int idx, input logic [W*DW-1:0] data);
      rsp_t e;
      if (exp_rsp_q.size() == 0) begin
         n_total++;
         $display("FAIL rsp_unexpected: wide=%0d idx=%0d rvalid at cycle %0d, none required", wide, idx, cyc);
      end else begin
         e = exp_rsp_q.pop_front();
         check("rsp_tag", {wide, 32'(idx), 32'(cyc)}, {e.wide, 32'(e.idx), 32'(e.due)});
         check("rsp_data", data, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_q.size() > 0) check("grant", {o_wide_gnt[sel], o_narrow_gnt[sel]}, exp_q.pop_front());
         for (int b = 0; b < N; b++)
            if (o_narrow_rvalid[sel][b]) mon_rsp(1'b0, b, (W*DW)'(o_narrow_rdata[sel][b*DW +: DW]));
         for (int g = 0; g < G; g++)
            if (o_wide_rvalid[sel][g]) mon_rsp(1'b1, g, o_wide_rdata[sel][g*W*DW +: W*DW]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      narrow_req = '0; narrow_we = '0; narrow_addr = '0; narrow_wdata = '0; narrow_be = '0;
      wide_req = '0; wide_we = '0; wide_addr = '0; wide_wdata = '0; wide_be = '0;
   endtask

   task automatic set_narrow(input int b, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [BW-1:0] be);
      narrow_req[b] = 1'b1;
      narrow_we[b] = we;
      narrow_addr[b*AW +: AW] = addr;
      narrow_wdata[b*DW +: DW] = wdata;
      narrow_be[b*BW +: BW] = be;
   endtask

   task automatic set_wide(input int g, input logic we, input logic [AW-1:0] addr);
      wide_req[g] = 1'b1;
      wide_we[g] = we;
      wide_addr[g*AW +: AW] = addr;
      wide_wdata[g*W*DW +: W*DW] = {4{64'hFACE_0000_CAFE_0000}};
      wide_be[g*W*BW +: W*BW] = '1;
   endtask

   task automatic exp_rsp(input logic wide, input int idx, input logic [W*DW-1:0] data);
      rsp_t e;
      e.wide = wide; e.idx = idx; e.due = cyc + LAT; e.data = data;
      exp_rsp_q.push_back(e);
   endtask

   task automatic issue(input logic [G+N-1:0] exp_gnt);
      exp_q.push_back(exp_gnt);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      clear_inputs();
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input int n);
      repeat (n) begin
         @(negedge clk);
         check("quiet_rvalid", {o_wide_rvalid[sel], o_narrow_rvalid[sel]}, '0);
      end
      @(posedge clk); #1;
   endtask

   localparam logic [W*DW-1:0] WideA = {64'hA3, 64'hA2, 64'hA1, 64'hA0};

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      clear_inputs();
      rst_n = 1'b0;
      sel = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs_zero",
            (W*DW)'(|{o_narrow_gnt[0], o_narrow_rvalid[0], o_narrow_rdata[0], o_wide_gnt[0],
                      o_wide_rvalid[0], o_wide_rdata[0], o_bank_req[0], o_bank_addr[0],
                      o_bank_we[0], o_bank_wdata[0], o_bank_be[0]}), '0);
      rst_n = 1'b1;
      idle(2);

      // Reset mid-read: the in-flight read must not answer after release.
      set_narrow(3, 1'b0, 10'h007, '0, '0);
      issue(10'b00_0000_1000);
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_quiet(4);

      // Mode 0: narrow bank 1 vs wide group 0, starvation bound 4.
      set_narrow(1, 1'b1, 10'h100, 64'h1111, 8'hFF);
      set_wide(0, 1'b1, 10'h100);
      for (int i = 0; i < 4; i++) issue(10'b00_0000_0010);
      issue(10'b01_0000_0000);
      issue(10'b00_0000_0010);
      issue(10'b00_0000_0010);
      idle(3);

      // Mode 2: full conflict on group 1 alternates owners.
      sel = 2;
      for (int b = 4; b < 8; b++) set_narrow(b, 1'b1, 10'h100, 64'h2222, 8'hFF);
      set_wide(1, 1'b1, 10'h100);
      for (int i = 0; i < 3; i++) begin
         issue(10'b00_1111_0000);
         issue(10'b10_0000_0000);
      end
      idle(4);

      // Mode 0: wide read addr 5, then a back-to-back narrow read on bank 0.
      sel = 0;
      set_wide(0, 1'b0, 10'h005);
      exp_rsp(1'b1, 0, WideA);
      issue(10'b01_0000_0000);
      clear_inputs();
      set_narrow(0, 1'b0, 10'h005, '0, '0);
      exp_rsp(1'b0, 0, (W*DW)'(64'hA0));
      issue(10'b00_0000_0001);
      idle(4);

      // Mode 1: narrow write bank 2 alongside narrow read bank 5 and wide read group 1.
      sel = 1;
      set_narrow(2, 1'b1, 10'h020, 64'h1234_5678_9ABC_DEF0, 8'h0F);
      set_narrow(5, 1'b0, 10'h030, '0, '0);
      set_wide(1, 1'b0, 10'h040);
      exp_rsp(1'b1, 1, {64'hBEEF0007_00000040, 64'hBEEF0006_00000040,
                        64'hBEEF0005_00000040, 64'hBEEF0004_00000040});
      issue(10'b10_0000_0100);
      clear_inputs();
      set_narrow(2, 1'b0, 10'h020, '0, '0);
      exp_rsp(1'b0, 2, (W*DW)'(64'hBEEF0002_9ABCDEF0));
      issue(10'b00_0000_0100);
      idle(4);

      // Mode 1: wide group 0 beats narrow banks 0/1; bank 6 proceeds untouched.
      for (int i = 0; i < 3; i++) begin
         clear_inputs();
         set_wide(0, 1'b0, 10'h005);
         set_narrow(0, 1'b0, 10'h001, '0, '0);
         set_narrow(1, 1'b1, 10'h002, 64'h3333, 8'hFF);
         set_narrow(6, 1'b0, 10'h011, '0, '0);
         exp_rsp(1'b0, 6, (W*DW)'(64'hBEEF0006_00000011));
         exp_rsp(1'b1, 0, WideA);
         issue(10'b01_0100_0000);
      end
      clear_inputs();

      for (int i = 0; i < 10 && exp_rsp_q.size() > 0; i++) @(posedge clk);
      #1;
      check("rsp_drain", (W*DW)'(exp_rsp_q.size()), '0);
      check("gnt_drain", (W*DW)'(exp_q.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
